// File: rtl/flicker_generator.sv
// flicker_generator: shared base-tick prescaler driving NCH indicator channels (OFF / ON / BLINK / ONESHOT).
// Optional feature macro FLICKER_PHASE_SYNC_EN adds the sync_all input that phase-aligns all BLINK channels.
module flicker_generator #(
  parameter int CLK_DIV  = 10_000_000,
  parameter int NCH      = 4,
  parameter int PERIOD_W = 8
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2*NCH-1:0]        mode,
  input  logic [PERIOD_W*NCH-1:0] period,
  input  logic [NCH-1:0]          load,
`ifdef FLICKER_PHASE_SYNC_EN
  input  logic                    sync_all,
`endif
  output logic                    tick,
  output logic [NCH-1:0]          flick,
  output logic [NCH-1:0]          busy
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  logic sync;
`ifdef FLICKER_PHASE_SYNC_EN
  assign sync = sync_all;
`else
  assign sync = 1'b0;
`endif

  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_next;

  always_comb begin
    // NOTE: default assignment first so every path drives pre_next and no latch is inferred.
    pre_next = pre_cnt;
    if (sync) begin
      pre_next = '0;
    end else if (enable) begin
      pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
    end
  end

  // tick is registered from the next count, so it is high exactly while pre_cnt == CLK_DIV-1.
  always_ff @(posedge Clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= pre_next;
      tick    <= enable && !sync && (pre_next == PRE_LAST);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [1:0]          ch_mode;
    logic [1:0]          prev_mode;
    logic [PERIOD_W-1:0] ch_period;
    logic [PERIOD_W-1:0] last;
    logic [PERIOD_W-1:0] cnt;
    logic                flick_r;
    logic                busy_r;

    assign ch_mode   = mode[2*c +: 2];
    assign ch_period = period[PERIOD_W*c +: PERIOD_W];
    // A zero period behaves as one tick.
    assign last      = (ch_period == '0) ? '0 : ch_period - PERIOD_W'(1);

    // Channels advance only on tick, which is already forced low while enable is low.
    always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
        prev_mode <= MODE_OFF;
        cnt       <= '0;
        flick_r   <= 1'b0;
        busy_r    <= 1'b0;
      end else begin
        prev_mode <= ch_mode;
        if (ch_mode != prev_mode) begin
          cnt     <= '0;
          busy_r  <= 1'b0;
          flick_r <= (ch_mode == MODE_ON) || (ch_mode == MODE_BLINK);
        end else if (sync && (ch_mode == MODE_BLINK)) begin
          cnt     <= '0;
          flick_r <= 1'b1;
        end else begin
          case (ch_mode)
            MODE_OFF: begin
              cnt     <= '0;
              flick_r <= 1'b0;
              busy_r  <= 1'b0;
            end
            MODE_ON: begin
              flick_r <= 1'b1;
              busy_r  <= 1'b0;
            end
            MODE_BLINK: begin
              busy_r <= 1'b0;
              if (load[c]) begin
                cnt     <= '0;
                flick_r <= 1'b1;
              end else if (tick) begin
                // >= so a period shortened below the running count wraps on the next tick.
                if (cnt >= last) begin
                  cnt     <= '0;
                  flick_r <= ~flick_r;
                end else begin
                  cnt <= cnt + PERIOD_W'(1);
                end
              end
            end
            default: begin
              if (load[c]) begin
                cnt     <= '0;
                flick_r <= 1'b1;
                busy_r  <= 1'b1;
              end else if (busy_r && tick) begin
                if (cnt >= last) begin
                  cnt     <= '0;
                  flick_r <= 1'b0;
                  busy_r  <= 1'b0;
                end else begin
                  cnt <= cnt + PERIOD_W'(1);
                end
              end
            end
          endcase
        end
      end
    end

    assign flick[c] = flick_r;
    assign busy[c]  = busy_r;
  end

endmodule

// File: tb/tb_flicker_generator.sv
// Directed self-checking bench for flicker_generator with CLK_DIV=4, NCH=2, PERIOD_W=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_flicker_generator;

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_ON      = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  logic        Clk;
  logic        reset;
  logic        enable;
  logic [3:0]  mode;
  logic [15:0] period;
  logic [1:0]  load;
  logic        tick;
  logic [1:0]  flick;
  logic [1:0]  busy;
`ifdef FLICKER_PHASE_SYNC_EN
  logic        sync_all;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  flicker_generator #(.CLK_DIV(4), .NCH(2), .PERIOD_W(8)) dut (
    .Clk     (Clk),
    .reset   (reset),
    .enable  (enable),
    .mode    (mode),
    .period  (period),
    .load    (load),
`ifdef FLICKER_PHASE_SYNC_EN
    .sync_all(sync_all),
`endif
    .tick    (tick),
    .flick   (flick),
    .busy    (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Stops at a falling edge where tick is visible, so the next rising edge is a tick edge.
  task automatic wait_tick(input string name);
    for (int k = 0; k < 16 && tick !== 1'b1; k++) cyc(1);
    n_checks++;
    if (tick !== 1'b1) $display("FAIL %s: tick=%b, required 1 within 16 clocks", name, tick);
    else n_pass++;
  endtask

  task automatic tick_edge(input string name);
    wait_tick(name);
    cyc(1);
  endtask

  task automatic test_reset();
    cyc(2);
    n_checks++;
    if ({tick, flick, busy} !== 5'b0)
      $display("FAIL reset_state: tick/flick/busy=%b, required 00000", {tick, flick, busy});
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_prescaler();
    logic exp;
    for (int n = 1; n <= 12; n++) begin
      cyc(1);
      exp = (n % 4 == 3);
      n_checks++;
      if (tick !== exp) $display("FAIL prescaler_tick clk%0d: tick=%b, required %b", n, tick, exp);
      else n_pass++;
    end
    n_checks++;
    if ({flick, busy} !== 4'b0) $display("FAIL all_off: flick/busy=%b, required 0000", {flick, busy});
    else n_pass++;
  endtask

  task automatic test_blink();
    logic exp;
    mode[1:0]   = M_BLINK;
    period[7:0] = 8'd3;
    cyc(1);
    n_checks++;
    if (flick[0] !== 1'b1) $display("FAIL blink_start: flick0=%b, required 1", flick[0]);
    else n_pass++;
    exp = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick_edge("blink_wait");
      if (t % 3 == 0) exp = ~exp;
      n_checks++;
      if (flick[0] !== exp) $display("FAIL blink_tick%0d: flick0=%b, required %b", t, flick[0], exp);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    logic [1:0] exp [8];
    exp = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    mode[3:2]    = M_ONESHOT;
    period[15:8] = 8'd2;
    cyc(1);
    for (int s = 0; s < 8; s++) begin
      case (s)
        1, 4, 6: begin load[1] = 1'b1; cyc(1); load[1] = 1'b0; end
        2, 3, 5, 7: tick_edge("oneshot_wait");
        default: ;
      endcase
      n_checks++;
      if ({flick[1], busy[1]} !== exp[s])
        $display("FAIL oneshot_step%0d: flick1/busy1=%b, required %b", s, {flick[1], busy[1]}, exp[s]);
      else n_pass++;
    end
    // Retriggered at tick 1: the pulse needs a second tick after the retrigger before clearing.
    tick_edge("oneshot_wait");
    n_checks++;
    if ({flick[1], busy[1]} !== 2'b00)
      $display("FAIL oneshot_retrigger_end: flick1/busy1=%b, required 00", {flick[1], busy[1]});
    else n_pass++;
  endtask

  task automatic test_period_change();
    period[7:0] = 8'd5;
    load[0] = 1'b1;
    cyc(1);
    load[0] = 1'b0;
    n_checks++;
    if (flick[0] !== 1'b1) $display("FAIL period_load: flick0=%b, required 1", flick[0]);
    else n_pass++;
    tick_edge("period_wait");
    tick_edge("period_wait");
    n_checks++;
    if (flick[0] !== 1'b1) $display("FAIL period_count2: flick0=%b, required 1", flick[0]);
    else n_pass++;
    period[7:0] = 8'd2;
    tick_edge("period_wait");
    n_checks++;
    if (flick[0] !== 1'b0) $display("FAIL period_shrink_wrap: flick0=%b, required 0", flick[0]);
    else n_pass++;
    period[7:0] = 8'd0;
    tick_edge("period_wait");
    n_checks++;
    if (flick[0] !== 1'b1) $display("FAIL period_zero_a: flick0=%b, required 1", flick[0]);
    else n_pass++;
    tick_edge("period_wait");
    n_checks++;
    if (flick[0] !== 1'b0) $display("FAIL period_zero_b: flick0=%b, required 0", flick[0]);
    else n_pass++;
  endtask

  task automatic test_enable();
    int bad_tick = 0;
    int bad_flick = 0;
    period[7:0] = 8'd3;
    load[0] = 1'b1;
    cyc(1);
    load[0] = 1'b0;
    tick_edge("enable_wait");
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) mode[3:2] = M_ON;
      cyc(1);
      if (tick !== 1'b0) bad_tick++;
      if (flick[0] !== 1'b1) bad_flick++;
      if (i == 5) begin
        n_checks++;
        if (flick[1] !== 1'b1) $display("FAIL on_while_disabled: flick1=%b, required 1", flick[1]);
        else n_pass++;
      end
    end
    n_checks++;
    if (bad_tick != 0) $display("FAIL disabled_tick: %0d clocks with tick high, required 0", bad_tick);
    else n_pass++;
    n_checks++;
    if (bad_flick != 0) $display("FAIL disabled_freeze: %0d clocks with flick0 changed, required 0", bad_flick);
    else n_pass++;
    enable = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      cyc(1);
      n_checks++;
      if (tick !== (n == 3)) $display("FAIL resume_tick clk%0d: tick=%b, required %b", n, tick, n == 3);
      else n_pass++;
    end
    cyc(1);
    n_checks++;
    if (flick[0] !== 1'b1) $display("FAIL resume_count: flick0=%b, required 1", flick[0]);
    else n_pass++;
    tick_edge("enable_wait");
    n_checks++;
    if (flick[0] !== 1'b0) $display("FAIL resume_toggle: flick0=%b, required 0", flick[0]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    mode[3:2]    = M_ONESHOT;
    period[15:8] = 8'd4;
    cyc(1);
    load[1] = 1'b1;
    cyc(1);
    load[1] = 1'b0;
    n_checks++;
    if (busy[1] !== 1'b1) $display("FAIL oneshot_before_reset: busy1=%b, required 1", busy[1]);
    else n_pass++;
    wait_tick("reset_wait");
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({tick, flick, busy} !== 5'b0)
      $display("FAIL async_reset: tick/flick/busy=%b, required 00000", {tick, flick, busy});
    else n_pass++;
    mode = 4'b0;
    @(negedge Clk);
    reset = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      cyc(1);
      n_checks++;
      if (tick !== (n == 3)) $display("FAIL post_reset_tick clk%0d: tick=%b, required %b", n, tick, n == 3);
      else n_pass++;
    end
  endtask

`ifdef FLICKER_PHASE_SYNC_EN
  task automatic test_sync();
    mode   = {M_BLINK, M_BLINK};
    period = {8'd2, 8'd2};
    cyc(1);
    tick_edge("sync_wait");
    load[0] = 1'b1;
    cyc(1);
    load[0] = 1'b0;
    sync_all = 1'b1;
    cyc(1);
    sync_all = 1'b0;
    n_checks++;
    if (flick !== 2'b11) $display("FAIL sync_start: flick=%b, required 11", flick);
    else n_pass++;
    tick_edge("sync_wait");
    n_checks++;
    if (flick !== 2'b11) $display("FAIL sync_tick1: flick=%b, required 11", flick);
    else n_pass++;
    tick_edge("sync_wait");
    n_checks++;
    if (flick !== 2'b00) $display("FAIL sync_tick2: flick=%b, required 00", flick);
    else n_pass++;
  endtask
`endif

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    mode   = 4'b0;
    period = 16'b0;
    load   = 2'b0;
`ifdef FLICKER_PHASE_SYNC_EN
    sync_all = 1'b0;
`endif
    test_reset();
    test_prescaler();
    test_blink();
    test_oneshot();
    test_period_change();
    test_enable();
    test_async_reset();
`ifdef FLICKER_PHASE_SYNC_EN
    test_sync();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
